// File: rtl/wokwi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wokwi_pkg
// Description : Shared mode encodings, ui_in field positions and LFSR
//               defaults for the 8-bit pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
package wokwi_pkg;

    typedef enum logic [1:0] {
        MODE_LOAD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LFSR = 2'b11
    } mode_e;

    localparam int EN_BIT   = 0;
    localparam int MODE_LSB = 1;
    localparam int MODE_MSB = 2;
    localparam int DATA_LSB = 3;
    localparam int DATA_MSB = 7;

    localparam logic [7:0] RESET_VALUE_DEFAULT = 8'h00;
    localparam logic [7:0] LFSR_TAPS_DEFAULT   = 8'hB8;
    localparam logic [7:0] LFSR_SEED_DEFAULT   = 8'h01;

endpackage
`default_nettype wire

// File: rtl/wokwi_lfsr_step.sv
`default_nettype none
// ============================================================================
// Module      : wokwi_lfsr_step
// Description : One right-shift Galois LFSR step with zero-state reseed.
// Revision    : 1.0 - initial release
// ============================================================================
module wokwi_lfsr_step
    import wokwi_pkg::*;
#(
    parameter logic [7:0] LFSR_TAPS = LFSR_TAPS_DEFAULT,
    parameter logic [7:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic [7:0] i_state,
    output logic [7:0] o_next
);

    // All-zero is a lock-up state for a Galois LFSR, so escape it via the seed
    always_comb begin
        o_next = (i_state >> 1) ^ (i_state[0] ? LFSR_TAPS : 8'h00);
        if (i_state == 8'h00) begin
            o_next = LFSR_SEED;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wokwi_395055359324730369.sv
`default_nettype none
// ============================================================================
// Module      : wokwi_395055359324730369
// Description : 8-bit programmable pattern generator (load/up/down/LFSR).
// Revision    : 1.0 - initial release
// ============================================================================
module wokwi_395055359324730369
    import wokwi_pkg::*;
#(
    parameter logic [7:0] RESET_VALUE = RESET_VALUE_DEFAULT,
    parameter logic [7:0] LFSR_TAPS   = LFSR_TAPS_DEFAULT,
    parameter logic [7:0] LFSR_SEED   = LFSR_SEED_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out
);

    logic [7:0] r_state;
    logic [7:0] w_next;
    logic [7:0] w_lfsr_next;
    logic       w_en;
    mode_e      w_mode;
    logic [4:0] w_data;

    assign w_en   = ui_in[EN_BIT];
    assign w_mode = mode_e'(ui_in[MODE_MSB:MODE_LSB]);
    assign w_data = ui_in[DATA_MSB:DATA_LSB];

    wokwi_lfsr_step #(
        .LFSR_TAPS (LFSR_TAPS),
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr_step (
        .i_state (r_state),
        .o_next  (w_lfsr_next)
    );

    always_comb begin
        w_next = r_state;
        if (w_en) begin
            case (w_mode)
                MODE_LOAD: w_next = {3'b000, w_data};
                MODE_UP:   w_next = r_state + 8'd1;
                MODE_DOWN: w_next = r_state - 8'd1;
                MODE_LFSR: w_next = w_lfsr_next;
                default:   w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RESET_VALUE;
        end else begin
            r_state <= w_next;
        end
    end

    assign uo_out = r_state;

endmodule
`default_nettype wire

// File: tb/tb_wokwi_395055359324730369.sv
`default_nettype none
// ============================================================================
// Module      : tb_wokwi_395055359324730369
// Description : Self-checking bench: directed vector table, corner sequences
//               and randomized stimulus against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wokwi_395055359324730369;

    logic       clk;
    logic       rst;
    logic [7:0] ui_in;
    logic [7:0] uo_out;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [7:0] ui;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    wokwi_395055359324730369 dut (
        .clk    (clk),
        .rst    (rst),
        .ui_in  (ui_in),
        .uo_out (uo_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] ui(input int en, input int mode, input int data);
        ui = 8'((data % 32) * 8 + (mode % 4) * 2 + (en % 2));
    endfunction

    // Reference model written straight from the mode rules, using integer arithmetic
    function automatic logic [7:0] model_next(input logic [7:0] s, input logic [7:0] u);
        int st;
        int en;
        int mode;
        int data;
        int res;
        st   = int'(s);
        en   = int'(u) % 2;
        mode = (int'(u) / 2) % 4;
        data = int'(u) / 8;
        res  = st;
        if (en == 1) begin
            if (mode == 0)      res = data;
            else if (mode == 1) res = (st + 1) % 256;
            else if (mode == 2) res = (st + 255) % 256;
            else if (st == 0)   res = 1;
            else                res = (st / 2) ^ ((st % 2 == 1) ? 184 : 0);
        end
        model_next = 8'(res);
    endfunction

    task automatic check(input string name, input logic [7:0] exp);
        n_checks++;
        if (uo_out !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", name, uo_out, exp);
        end
    endtask

    task automatic step(input logic [7:0] u);
        ui_in = u;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] m;
        logic       seen_zero;
        logic       early_repeat;

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        ui_in    = 8'hFF;
        #1;
        check("reset_no_clock", 8'h00);

        @(negedge clk);
        rst = 1'b0;

        // Directed vectors, applied one clock each starting from reset state
        vecs.push_back('{ui(0, 3, 5'h1F), 8'h00});
        vecs.push_back('{ui(0, 0, 5'h1F), 8'h00});
        vecs.push_back('{ui(0, 1, 5'h0A), 8'h00});
        vecs.push_back('{ui(1, 0, 5'h15), 8'h15});
        vecs.push_back('{ui(0, 0, 5'h03), 8'h15});
        vecs.push_back('{ui(1, 0, 5'h1F), 8'h1F});
        vecs.push_back('{ui(1, 1, 5'h00), 8'h20});
        vecs.push_back('{ui(1, 1, 5'h00), 8'h21});
        vecs.push_back('{ui(1, 0, 5'h00), 8'h00});
        vecs.push_back('{ui(1, 2, 5'h00), 8'hFF});
        vecs.push_back('{ui(1, 2, 5'h00), 8'hFE});
        vecs.push_back('{ui(1, 0, 5'h00), 8'h00});
        vecs.push_back('{ui(1, 3, 5'h00), 8'h01});
        vecs.push_back('{ui(1, 3, 5'h00), 8'hB8});
        vecs.push_back('{ui(1, 3, 5'h00), 8'h5C});
        vecs.push_back('{ui(1, 3, 5'h00), 8'h2E});
        vecs.push_back('{ui(1, 3, 5'h00), 8'h17});
        vecs.push_back('{ui(1, 3, 5'h00), 8'hB3});
        vecs.push_back('{ui(1, 0, 5'h0F), 8'h0F});
        vecs.push_back('{ui(1, 1, 5'h00), 8'h10});
        vecs.push_back('{ui(1, 2, 5'h00), 8'h0F});
        vecs.push_back('{ui(1, 0, 5'h00), 8'h00});

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ui);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // 256 UP steps from zero wrap back to zero
        for (int i = 0; i < 256; i++) begin
            step(ui(1, 1, 0));
            if (i == 254) check("up_ff_before_wrap", 8'hFF);
        end
        check("up_256_wrap", 8'h00);

        // LFSR period is exactly 255 and never visits zero
        step(ui(1, 3, 0));
        check("lfsr_seed", 8'h01);
        seen_zero    = 1'b0;
        early_repeat = 1'b0;
        for (int i = 1; i <= 255; i++) begin
            step(ui(1, 3, 0));
            if (uo_out == 8'h00) seen_zero = 1'b1;
            if (i < 255 && uo_out == 8'h01) early_repeat = 1'b1;
        end
        check("lfsr_period_255", 8'h01);
        n_checks++;
        if (seen_zero || early_repeat) begin
            n_fail++;
            $display("FAIL lfsr_orbit: zero_seen=%0d early_repeat=%0d, required 0 and 0",
                     seen_zero, early_repeat);
        end

        // Asynchronous reset while counting at 8'h42
        step(ui(1, 0, 5'h1F));
        for (int i = 0; i < 8'h23; i++) step(ui(1, 1, 0));
        check("count_to_42", 8'h42);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_mid_run", 8'h00);
        @(negedge clk);
        rst = 1'b0;
        step(ui(1, 1, 0));
        check("resume_after_reset", 8'h01);

        // Randomized stimulus against the model, with occasional resets
        m = uo_out;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                ui_in = 8'($urandom);
                rst   = 1'b1;
                #1;
                m = 8'h00;
                check($sformatf("rand_rst%0d", i), m);
                @(posedge clk);
                #1;
                rst = 1'b0;
            end else begin
                logic [7:0] u;
                u = 8'($urandom);
                // Bias toward enabled LFSR/count so long runs occur
                if ($urandom_range(0, 3) != 0) u[0] = 1'b1;
                m = model_next(m, u);
                step(u);
            end
            check($sformatf("rand%0d", i), m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/wokwi_395055359324730369.md
Name: wokwi_395055359324730369

Overview:
- Small 8-bit programmable pattern generator, packaged as a TinyTapeout microtile core.
- One 8-bit state register is driven onto uo_out.
- ui_in selects enable, operating mode (load / count up / count down / LFSR) and a 5-bit load value.
- Sits directly under the tt_um wrapper. The wrapper connects ui_in/uo_out straight through and supplies clk and rst.

Parameters:
- RESET_VALUE, 8'h00, state register value while rst is high.
- LFSR_TAPS, 8'hB8, Galois feedback mask (x^8+x^6+x^5+x^4+1).
- LFSR_SEED, 8'h01, value loaded in LFSR mode when state is 0.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ui_in  input  8  [0]=en, [2:1]=mode, [7:3]=data.
- uo_out  output  8  current state register value (registered, no combinational path from ui_in).

Behaviour:
- Reset: rst high asynchronously forces state=RESET_VALUE, so uo_out=8'h00 immediately. Reset mid-operation aborts any mode. The first update after rst deasserts happens at the next rising clk edge.
- ui_in is treated as synchronous to clk; there are no input synchronizers. It is sampled at each rising edge.
- en=0: state holds in every mode, including load.
- en=1, mode=2'b00 (LOAD): state <= {3'b000, data}.
- en=1, mode=2'b01 (UP): state <= state+1, mod 256; 8'hFF wraps to 8'h00.
- en=1, mode=2'b10 (DOWN): state <= state-1, mod 256; 8'h00 wraps to 8'hFF.
- en=1, mode=2'b11 (LFSR):
  - If state==0: state <= LFSR_SEED (lock-up escape).
  - Otherwise: right-shift Galois step, next = (state>>1) ^ (state[0] ? LFSR_TAPS : 0).
  - Period is 255 over nonzero values.
- Latency: one clock from sampled inputs to the new uo_out value.
- Mode changes take effect on the same edge they are sampled. No pipeline and no pending state.
- All arithmetic is 8 bits unsigned; carries and borrows are discarded.

Decomposition:
- Shared package wokwi_pkg holds:
  - mode encodings MODE_LOAD=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_LFSR=2'b11;
  - the ui_in field bit positions (EN_BIT, MODE_LSB/MSB, DATA_LSB/MSB);
  - default constants for LFSR_TAPS and LFSR_SEED.
- One natural sub-module, wokwi_lfsr_step: purely combinational, 8-bit state in, 8-bit next out, including the zero-reseed rule. Parameterised by LFSR_TAPS and LFSR_SEED.
- Top level holds the register, the mode mux and the output assignment.

Test Plan:
- Reset: rst=1 with any ui_in -> uo_out=8'h00 without a clock edge. Release rst, en=0 for 3 clocks -> uo_out stays 8'h00.
- Load then hold: en=1, mode=00, data=5'h15, 1 clock -> uo_out=8'h15. Set en=0 and change data to 5'h03 -> uo_out stays 8'h15.
- Count wrap:
  - Load 5'h1F (8'h1F), en=1, mode=01 -> 8'h20, 8'h21 over 2 clocks.
  - Start DOWN from 8'h00 after reset -> 8'hFF, 8'hFE.
  - 256 UP clocks from 8'h00 -> 8'h00 again.
- LFSR sequence:
  - From reset (0), en=1, mode=11 -> 8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3 on successive clocks.
  - After 255 further steps from 8'h01 -> 8'h01 again, never 8'h00.
- Asynchronous reset mid-run: while counting UP at 8'h42, assert rst between clock edges -> uo_out=8'h00 immediately. Deassert -> counting resumes from 8'h00 (8'h01 after the next edge).
- Mode switch on the fly: UP at 8'h10, change mode to DOWN -> next edge gives 8'h0F. Then change to LOAD with data=5'h00 -> 8'h00.
